// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: runs one load/store access per start request and signals done.
// Define MEM_CTRL_BYTE_EN to support the byte loads OP_LBU/OP_LBS; otherwise they are illegal.
module mem_stage_ctrl #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [3:0] OP_LW       = 4'h4,
    parameter logic [3:0] OP_LBU      = 4'h5,
    parameter logic [3:0] OP_LBS      = 4'h6,
    parameter logic [3:0] OP_SW       = 4'h7,
    parameter logic [3:0] OP_SV       = 4'h8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] opcode,
    output logic       enable_MEM,
    output logic       Sv_Imm,
    output logic       MemRd,
    output logic       MemWr,
    output logic       ExtOpMemory,
    output logic       MemOut,
    output logic       wb_en,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, FINISH} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_opcode;
    logic [3:0] r_cnt;

    logic w_isStore;
    logic w_isLoad;
    logic w_isByte;
    logic w_extOp;
    logic w_byteReject;
    logic w_legal;

    assign w_isStore = (r_opcode == OP_SW) || (r_opcode == OP_SV);

`ifdef MEM_CTRL_BYTE_EN
    assign w_isByte     = (r_opcode == OP_LBU) || (r_opcode == OP_LBS);
    assign w_extOp      = (r_opcode == OP_LBS);
    assign w_byteReject = 1'b0;
`else
    // Byte loads are explicitly rejected so they report illegal even if encodings overlap.
    assign w_isByte     = 1'b0;
    assign w_extOp      = 1'b0;
    assign w_byteReject = (r_opcode == OP_LBU) || (r_opcode == OP_LBS);
`endif

    assign w_isLoad = ((r_opcode == OP_LW) || w_isByte) && !w_byteReject;
    assign w_legal  = (w_isStore || w_isLoad) && !w_byteReject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_opcode <= 4'h0;
            r_cnt    <= 4'h0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_opcode <= opcode;
            end
            if (r_state == ACCESS) begin
                r_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (r_state == WAIT && r_cnt != 4'h0) begin
                r_cnt <= r_cnt - 4'h1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        enable_MEM  = 1'b0;
        busy        = 1'b0;
        Sv_Imm      = 1'b0;
        MemOut      = 1'b0;
        ExtOpMemory = 1'b0;
        MemRd       = 1'b0;
        MemWr       = 1'b0;
        wb_en       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;

        // Decode controls stay stable for the whole access once the opcode is latched.
        if (r_state != IDLE) begin
            enable_MEM  = 1'b1;
            busy        = 1'b1;
            Sv_Imm      = (r_opcode == OP_SV);
            MemOut      = w_isByte;
            ExtOpMemory = w_extOp;
        end

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_next = w_legal ? ACCESS : FINISH;
            end
            ACCESS: begin
                w_next = FINISH;
                if (w_isStore) begin
                    MemWr = 1'b1;
                end else if (w_isLoad) begin
                    MemRd = 1'b1;
                    if (WAIT_CYCLES != 0) begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                MemRd = 1'b1;
                if (r_cnt == 4'h0) begin
                    w_next = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                MemRd   = w_isLoad;
                wb_en   = w_isLoad;
                illegal = !w_legal;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-cycle comparison against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int         WAIT_C = 2;
    localparam logic [3:0] OP_LW  = 4'h4;
    localparam logic [3:0] OP_LBU = 4'h5;
    localparam logic [3:0] OP_LBS = 4'h6;
    localparam logic [3:0] OP_SW  = 4'h7;
    localparam logic [3:0] OP_SV  = 4'h8;
`ifdef MEM_CTRL_BYTE_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic       enable_MEM, Sv_Imm, MemRd, MemWr, ExtOpMemory, MemOut;
    logic       wb_en, busy, done, illegal;
    logic [9:0] obsVec;

    int nChecks = 0;
    int nFails  = 0;

    mem_stage_ctrl #(.WAIT_CYCLES(WAIT_C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .enable_MEM(enable_MEM), .Sv_Imm(Sv_Imm), .MemRd(MemRd), .MemWr(MemWr),
        .ExtOpMemory(ExtOpMemory), .MemOut(MemOut), .wb_en(wb_en),
        .busy(busy), .done(done), .illegal(illegal)
    );

    assign obsVec = {enable_MEM, Sv_Imm, MemRd, MemWr, ExtOpMemory, MemOut,
                     wb_en, busy, done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isStoreOp(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SV);
    endfunction

    function automatic bit isByteOp(input logic [3:0] op);
        return BYTE_EN && ((op == OP_LBU) || (op == OP_LBS));
    endfunction

    function automatic bit isLoadOp(input logic [3:0] op);
        return (op == OP_LW) || isByteOp(op);
    endfunction

    function automatic int latency(input logic [3:0] op);
        if (isStoreOp(op)) return 3;
        if (isLoadOp(op)) return 3 + WAIT_C;
        return 2;
    endfunction

    // Expected outputs k cycles after the start cycle of a single transaction (0 = idle).
    function automatic logic [9:0] model(input logic [3:0] op, input int k);
        int  lat;
        bit  st, ld;
        lat = latency(op);
        st  = isStoreOp(op);
        ld  = isLoadOp(op);
        if (k < 1 || k > lat) return 10'b0;
        return {1'b1, (op == OP_SV), (ld && k >= 2), (st && k == 2),
                (BYTE_EN && op == OP_LBS), isByteOp(op),
                (ld && k == lat), 1'b1, (k == lat), (k == lat && !st && !ld)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] op;
        logic [9:0] exp;
        rst_n  = 1'b1;
        start  = 1'b0;
        opcode = 4'h0;
        #3 rst_n = 1'b0;
        #1;
        nChecks++;
        if (obsVec !== 10'b0) begin
            nFails++;
            $display("[TB] FAIL reset_state got=%b exp=%b", obsVec, 10'b0);
        end
        start  = 1'b1;
        opcode = OP_SW;
        for (int i = 0; i < 2; i++) begin
            step();
            nChecks++;
            if (obsVec !== 10'b0) begin
                nFails++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", i, obsVec, 10'b0);
            end
        end
        rst_n  = 1'b1;
        op     = OP_LW;
        opcode = op;
        for (int k = 1; k <= latency(op) + 1; k++) begin
            step();
            start  = 1'b0;
            opcode = 4'($urandom);
            exp    = model(op, k);
            nChecks++;
            if (obsVec !== exp) begin
                nFails++;
                $display("[TB] FAIL post_reset op=%h k=%0d got=%b exp=%b", op, k, obsVec, exp);
            end
        end
    endtask

    task automatic test_store();
        logic [3:0] ops[2];
        logic [9:0] exp;
        int wrCycles, doneAt;
        ops = '{OP_SW, OP_SV};
        foreach (ops[i]) begin
            wrCycles = 0;
            doneAt   = 0;
            start    = 1'b1;
            opcode   = ops[i];
            for (int k = 1; k <= latency(ops[i]) + 1; k++) begin
                step();
                start  = 1'b0;
                opcode = 4'($urandom);
                exp    = model(ops[i], k);
                if (MemWr) wrCycles++;
                if (done) doneAt = k;
                nChecks++;
                if (obsVec !== exp) begin
                    nFails++;
                    $display("[TB] FAIL store op=%h k=%0d got=%b exp=%b", ops[i], k, obsVec, exp);
                end
            end
            nChecks++;
            if (wrCycles !== 1 || doneAt !== 3) begin
                nFails++;
                $display("[TB] FAIL store_timing op=%h wr=%0d done_at=%0d exp wr=1 done_at=3",
                         ops[i], wrCycles, doneAt);
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] ops[3];
        logic [9:0] exp;
        int rdCycles, doneAt, rdExp;
        ops = '{OP_LW, OP_LBU, OP_LBS};
        foreach (ops[i]) begin
            rdCycles = 0;
            doneAt   = 0;
            rdExp    = isLoadOp(ops[i]) ? WAIT_C + 2 : 0;
            start    = 1'b1;
            opcode   = ops[i];
            for (int k = 1; k <= latency(ops[i]) + 1; k++) begin
                step();
                start  = 1'b0;
                opcode = 4'($urandom);
                exp    = model(ops[i], k);
                if (MemRd) rdCycles++;
                if (done) doneAt = k;
                nChecks++;
                if (obsVec !== exp) begin
                    nFails++;
                    $display("[TB] FAIL load op=%h k=%0d got=%b exp=%b", ops[i], k, obsVec, exp);
                end
            end
            nChecks++;
            if (rdCycles !== rdExp || doneAt !== latency(ops[i])) begin
                nFails++;
                $display("[TB] FAIL load_timing op=%h rd=%0d done_at=%0d exp rd=%0d done_at=%0d",
                         ops[i], rdCycles, doneAt, rdExp, latency(ops[i]));
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] ops[3];
        logic [9:0] exp;
        int doneAt;
        ops = '{4'hF, 4'h0, 4'h9};
        foreach (ops[i]) begin
            doneAt = 0;
            start  = 1'b1;
            opcode = ops[i];
            for (int k = 1; k <= 3; k++) begin
                step();
                start  = 1'b0;
                opcode = 4'($urandom);
                exp    = model(ops[i], k);
                if (done && illegal) doneAt = k;
                nChecks++;
                if (obsVec !== exp) begin
                    nFails++;
                    $display("[TB] FAIL illegal op=%h k=%0d got=%b exp=%b", ops[i], k, obsVec, exp);
                end
            end
            nChecks++;
            if (doneAt !== 2) begin
                nFails++;
                $display("[TB] FAIL illegal_timing op=%h done_at=%0d exp=2", ops[i], doneAt);
            end
        end
    endtask

    // A start held in the FINISH cycle must be ignored; the one in the following IDLE cycle is taken.
    task automatic test_back_to_back();
        logic [9:0] exp;
        start  = 1'b1;
        opcode = OP_SV;
        for (int k = 1; k <= 3; k++) begin
            step();
            start  = 1'b0;
            opcode = 4'($urandom);
            exp    = model(OP_SV, k);
            nChecks++;
            if (obsVec !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_sv k=%0d got=%b exp=%b", k, obsVec, exp);
            end
        end
        start  = 1'b1;
        opcode = OP_SW;
        step();
        nChecks++;
        if (obsVec !== 10'b0) begin
            nFails++;
            $display("[TB] FAIL b2b_gap got=%b exp=%b", obsVec, 10'b0);
        end
        opcode = OP_LW;
        for (int k = 1; k <= latency(OP_LW) + 1; k++) begin
            step();
            start  = 1'b0;
            opcode = 4'($urandom);
            exp    = model(OP_LW, k);
            nChecks++;
            if (obsVec !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_lw k=%0d got=%b exp=%b", k, obsVec, exp);
            end
        end
    endtask

    task automatic test_reset_midaccess();
        logic [9:0] exp;
        start  = 1'b1;
        opcode = OP_LW;
        for (int k = 1; k <= 3; k++) begin
            step();
            start  = 1'b0;
            exp    = model(OP_LW, k);
            nChecks++;
            if (obsVec !== exp) begin
                nFails++;
                $display("[TB] FAIL midrst_pre k=%0d got=%b exp=%b", k, obsVec, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if (obsVec !== 10'b0) begin
            nFails++;
            $display("[TB] FAIL midrst_async got=%b exp=%b", obsVec, 10'b0);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            nChecks++;
            if (obsVec !== 10'b0) begin
                nFails++;
                $display("[TB] FAIL midrst_after cyc=%0d got=%b exp=%b", i, obsVec, 10'b0);
            end
        end
        start  = 1'b1;
        opcode = OP_SW;
        for (int k = 1; k <= latency(OP_SW) + 1; k++) begin
            step();
            start  = 1'b0;
            exp    = model(OP_SW, k);
            nChecks++;
            if (obsVec !== exp) begin
                nFails++;
                $display("[TB] FAIL midrst_recover k=%0d got=%b exp=%b", k, obsVec, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [9:0] exp;
        int gap, lat;
        for (int t = 0; t < 40; t++) begin
            op  = 4'($urandom_range(0, 15));
            gap = $urandom_range(0, 2);
            lat = latency(op);
            for (int g = 0; g < gap; g++) begin
                step();
                opcode = 4'($urandom);
                nChecks++;
                if (obsVec !== 10'b0) begin
                    nFails++;
                    $display("[TB] FAIL rand_idle t=%0d got=%b exp=%b", t, obsVec, 10'b0);
                end
            end
            start  = 1'b1;
            opcode = op;
            for (int k = 1; k <= lat + 1; k++) begin
                step();
                start  = 1'b0;
                opcode = 4'($urandom);
                exp    = model(op, k);
                nChecks++;
                if (obsVec !== exp) begin
                    nFails++;
                    $display("[TB] FAIL rand t=%0d op=%h k=%0d got=%b exp=%b", t, op, k, obsVec, exp);
                end
                if (k == lat && $urandom_range(0, 1) == 1) start = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_illegal();
        test_back_to_back();
        test_reset_midaccess();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra cycles MemRd is held before load data is valid (0..15).
REQ-002 SHALL have parameter OP_LW, default 4'h4, word-load opcode.
REQ-003 SHALL have parameter OP_LBU, default 4'h5, byte-load zero-extend opcode.
REQ-004 SHALL have parameter OP_LBS, default 4'h6, byte-load sign-extend opcode.
REQ-005 SHALL have parameter OP_SW, default 4'h7, word-store opcode (address = ALUres, data = BusB).
REQ-006 SHALL have parameter OP_SV, default 4'h8, store-immediate opcode (address = BusA, data = Imm16).
REQ-007 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port start  input  1  one-cycle request from the main control unit to run the MEM stage.
REQ-010 SHALL have port opcode  input  4  instruction opcode, sampled only when start is accepted.
REQ-011 SHALL have ports enable_MEM, Sv_Imm, MemRd, MemWr, ExtOpMemory, MemOut  output  1 each  MEM-stage controls.
REQ-012 SHALL have port wb_en  output  1  one-cycle pulse: dataOut valid, write it to the register file.
REQ-013 SHALL have port busy  output  1  high from start acceptance until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at stage completion.
REQ-015 SHALL have port illegal  output  1  one-cycle pulse with done when the latched opcode is not supported.

Function
REQ-016 SHALL implement states IDLE, SETUP, ACCESS, WAIT, FINISH.
REQ-017 IDLE: start=1 SHALL latch opcode, set busy, and go to SETUP. start while busy SHALL be ignored.
REQ-018 SETUP (1 cycle): enable_MEM=1, with Sv_Imm, ExtOpMemory, and MemOut driven from the latched opcode. A non-memory or unsupported opcode SHALL go straight to FINISH.
REQ-019 Decode: Sv_Imm=1 only for OP_SV; MemOut=1 for OP_LBU/OP_LBS, 0 otherwise; ExtOpMemory=1 only for OP_LBS.
REQ-020 ACCESS (1 cycle): stores SHALL assert MemWr for exactly this cycle, then go to FINISH. Loads SHALL assert MemRd and go to WAIT, or go to FINISH when WAIT_CYCLES=0.
REQ-021 WAIT: MemRd SHALL stay high. A 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; exit to FINISH when it reaches 0.
REQ-022 FINISH (1 cycle): done=1, busy=0 on the next edge, then return to IDLE. Loads SHALL assert wb_en. MemRd SHALL remain high in FINISH for loads so dataOut stays stable.
REQ-023 MemRd and MemWr SHALL never be high together. MemWr SHALL never be high outside ACCESS.
REQ-024 Latency from start to done SHALL be: stores 3 cycles; loads 3+WAIT_CYCLES cycles; non-memory opcodes 2 cycles.
REQ-025 start in the FINISH cycle SHALL be ignored. start in IDLE one cycle after done SHALL be accepted (back-to-back throughput).
REQ-026 enable_MEM SHALL be high in every state except IDLE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, clear the counter and latched opcode, and drive every output to 0, including mid-access. No pending write SHALL complete after reset.
REQ-028 After rst_n rises, the first accepted start SHALL be on the first clk edge with start=1.

Configuration
REQ-029 Macro MEM_CTRL_BYTE_EN defined: OP_LBU/OP_LBS SHALL be supported as in REQ-019/020.
REQ-030 MEM_CTRL_BYTE_EN undefined: OP_LBU/OP_LBS SHALL be treated as unsupported (SETUP->FINISH, illegal=1, no MemRd, no wb_en). MemOut and ExtOpMemory SHALL be tied 0.

Verification
REQ-031 WAIT_CYCLES=1, start with OP_SW -> MemWr high exactly 1 cycle (ACCESS), Sv_Imm=0, done 3 cycles after start, wb_en never high.
REQ-032 WAIT_CYCLES=2, OP_LBS with BYTE_EN -> MemRd high 4 cycles, MemOut=1, ExtOpMemory=1, done+wb_en 5 cycles after start.
REQ-033 Opcode 4'hF -> done+illegal 2 cycles after start, MemRd=MemWr=0 throughout.
REQ-034 OP_SV then OP_LW back-to-back (second start the cycle after done) -> Sv_Imm=1 only in the first op, both complete, no overlap of MemRd/MemWr.
REQ-035 rst_n pulled low during WAIT of OP_LW -> all outputs 0 asynchronously, no wb_en, IDLE after release.
REQ-036 BYTE_EN undefined, OP_LBU -> illegal=1 at done, MemRd never asserted.
